alu_control: RTL and testbench
==============================

Name: alu_control

Overview:
- Decodes the main-control ALUOp class plus instruction funct3/funct7 into a 4-bit ALU operation select and a 32-bit word-operation flag.
- Sits in the ID/EX path of the pipelined RISC-V-style core, between the main control decoder and the ALU.
- Outputs are registered: one clock of latency, synchronous active-high reset.

Parameters:
- None. All encodings below are fixed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- ALUOp  input  3  instruction class from main control.
- funct3  input  3  instruction funct3 field.
- funct7  input  7  instruction funct7 field.
- ALUControl  output  4  ALU operation select, registered.
- WordOp  output  1  1 = 32-bit word operation (result sign-extended by the ALU), registered.

Behaviour:
- One clock, synchronous active-high reset. On a rising clk with rst=1: ALUControl=4'b0000 and WordOp=0. rst takes priority over any decode.
- Otherwise, on each rising clk, the outputs load the combinational decode of the current ALUOp, funct3 and funct7. Latency is exactly 1 cycle; there is no handshake or enable.
- ALUControl encoding: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLL=0110, SRL=0111, PASS_B=1000. Codes 1001-1111 are never generated.
- ALUOp=000, R-type, decoded by funct3:
  - 0 -> SLT; 1 -> ADD; 2 -> SRL; 3 -> XOR; 4 -> SLL; 5 -> OR; 6 -> SUB; 7 -> AND.
  - WordOp=1 only when funct3=1 and funct7=7'h20 (addw). funct3=1 with any other funct7 gives ADD with WordOp=0.
  - For all other funct3 values, funct7 is ignored and WordOp=0.
- ALUOp=001, I-type arithmetic/logical, decoded by funct3:
  - 0 -> ADD with WordOp=1 (addiw); 1 -> ADD with WordOp=0.
  - 2 -> SRL; 3 -> XOR; 4 -> SLL; 5 -> SLT; 6 -> AND; 7 -> OR; all with WordOp=0.
  - funct7 is ignored.
- ALUOp=010 (store): ADD, WordOp=0. funct3/funct7 ignored.
- ALUOp=011 (load): ADD, WordOp=0. funct3/funct7 ignored.
- ALUOp=100 (reserved): ADD, WordOp=0.
- ALUOp=101 (branch): SUB, WordOp=0. funct3 ignored; branch condition evaluation is outside this block.
- ALUOp=110 (jal/jalr): ADD, WordOp=0.
- ALUOp=111 (lui): PASS_B, WordOp=0.
- X/Z on inputs: no requirement, but the decode must use a full case with the default ADD/WordOp=0 so that no latch is inferred.
- Input changes between edges do not affect the outputs until the next rising edge.
- Reset asserted mid-stream clears the outputs at that edge. The first edge after rst deasserts loads the decode of the inputs present at that edge.

Test Plan:
- Reset: hold rst=1 with ALUOp=000, funct3=6 -> after the edge ALUControl=0000, WordOp=0. Release rst -> after the next edge ALUControl=0001.
- R-type sweep: ALUOp=000, funct7=00, funct3 0..7 -> SLT, ADD, SRL, XOR, SLL, OR, SUB, AND, each with WordOp=0. Then funct3=1, funct7=20 -> 0000 with WordOp=1.
- I-type sweep: ALUOp=001, funct3=0 -> 0000 with WordOp=1. funct3=7 -> 0011; funct3=6 -> 0010; funct3=1 -> 0000; all with WordOp=0.
- Fixed classes:
  - ALUOp=010 with funct3=2 or 0 -> 0000/0.
  - ALUOp=011 with funct3=0 or 2 -> 0000/0.
  - ALUOp=101 with funct3=0 or 1 -> 0001/0.
  - ALUOp=110 -> 0000/0.
  - ALUOp=111 -> 1000/0.
  - ALUOp=100 -> 0000/0.
- Latency: change the inputs mid-cycle -> outputs are unchanged until the next rising edge and update exactly one cycle later.
- Back-to-back: different decodes on consecutive cycles -> each result appears on the cycle after it was applied, with no stale or merged values.

Source files
------------

// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
// Module      : alu_control
// Description : ALU control decoder for the ID/EX stage. Combines the
//               main-control ALUOp instruction class with the instruction
//               funct3/funct7 fields. It produces a 4-bit ALU operation
//               select and a 32-bit word-operation flag. Both outputs are
//               registered, so results appear one clock after the inputs
//               are sampled.
// Ports       : clk        - system clock, rising-edge active
//               rst        - synchronous active-high reset
//               ALUOp      - [2:0] instruction class from main control
//               funct3     - [2:0] instruction funct3 field
//               funct7     - [6:0] instruction funct7 field
//               ALUControl - [3:0] registered ALU operation select
//               WordOp     - registered 32-bit word-operation flag
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] ALUControl,
    output logic       WordOp
);

    // ALU operation select encodings
    localparam logic [3:0] c_ALU_ADD    = 4'b0000;
    localparam logic [3:0] c_ALU_SUB    = 4'b0001;
    localparam logic [3:0] c_ALU_AND    = 4'b0010;
    localparam logic [3:0] c_ALU_OR     = 4'b0011;
    localparam logic [3:0] c_ALU_XOR    = 4'b0100;
    localparam logic [3:0] c_ALU_SLT    = 4'b0101;
    localparam logic [3:0] c_ALU_SLL    = 4'b0110;
    localparam logic [3:0] c_ALU_SRL    = 4'b0111;
    localparam logic [3:0] c_ALU_PASS_B = 4'b1000;

    // Instruction classes from main control
    localparam logic [2:0] c_OP_RTYPE  = 3'b000;
    localparam logic [2:0] c_OP_ITYPE  = 3'b001;
    localparam logic [2:0] c_OP_STORE  = 3'b010;
    localparam logic [2:0] c_OP_LOAD   = 3'b011;
    localparam logic [2:0] c_OP_RSVD   = 3'b100;
    localparam logic [2:0] c_OP_BRANCH = 3'b101;
    localparam logic [2:0] c_OP_JUMP   = 3'b110;
    localparam logic [2:0] c_OP_LUI    = 3'b111;

    // funct7 value that marks the word-sized add in the R-type class
    localparam logic [6:0] c_FUNCT7_WORD = 7'h20;

    logic [3:0] w_alu_control;
    logic       w_word_op;
    logic [3:0] r_alu_control;
    logic       r_word_op;

    // Combinational decode. ADD/WordOp=0 is the default for every path
    // that does not override it, including unknown inputs.
    always_comb begin
        w_alu_control = c_ALU_ADD;
        w_word_op     = 1'b0;
        case (ALUOp)
            c_OP_RTYPE: begin
                case (funct3)
                    3'd0: w_alu_control = c_ALU_SLT;
                    3'd1: begin
                        w_alu_control = c_ALU_ADD;
                        w_word_op     = (funct7 == c_FUNCT7_WORD);
                    end
                    3'd2: w_alu_control = c_ALU_SRL;
                    3'd3: w_alu_control = c_ALU_XOR;
                    3'd4: w_alu_control = c_ALU_SLL;
                    3'd5: w_alu_control = c_ALU_OR;
                    3'd6: w_alu_control = c_ALU_SUB;
                    3'd7: w_alu_control = c_ALU_AND;
                    default: begin
                        w_alu_control = c_ALU_ADD;
                        w_word_op     = 1'b0;
                    end
                endcase
            end
            c_OP_ITYPE: begin
                // funct7 carries immediate bits here and is not decoded
                case (funct3)
                    3'd0: begin
                        w_alu_control = c_ALU_ADD;
                        w_word_op     = 1'b1;
                    end
                    3'd1: w_alu_control = c_ALU_ADD;
                    3'd2: w_alu_control = c_ALU_SRL;
                    3'd3: w_alu_control = c_ALU_XOR;
                    3'd4: w_alu_control = c_ALU_SLL;
                    3'd5: w_alu_control = c_ALU_SLT;
                    3'd6: w_alu_control = c_ALU_AND;
                    3'd7: w_alu_control = c_ALU_OR;
                    default: begin
                        w_alu_control = c_ALU_ADD;
                        w_word_op     = 1'b0;
                    end
                endcase
            end
            c_OP_STORE:  w_alu_control = c_ALU_ADD;
            c_OP_LOAD:   w_alu_control = c_ALU_ADD;
            c_OP_RSVD:   w_alu_control = c_ALU_ADD;
            // Comparison is done by subtraction; the branch condition
            // itself is resolved elsewhere.
            c_OP_BRANCH: w_alu_control = c_ALU_SUB;
            c_OP_JUMP:   w_alu_control = c_ALU_ADD;
            c_OP_LUI:    w_alu_control = c_ALU_PASS_B;
            default: begin
                w_alu_control = c_ALU_ADD;
                w_word_op     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_control <= c_ALU_ADD;
            r_word_op     <= 1'b0;
        end else begin
            r_alu_control <= w_alu_control;
            r_word_op     <= w_word_op;
        end
    end

    assign ALUControl = r_alu_control;
    assign WordOp     = r_word_op;

endmodule
`default_nettype wire

// File: tb/tb_alu_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_control
// Description : Directed self-checking bench for alu_control. Inputs change
//               on the falling edge; outputs are sampled 1 ns after the
//               rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control;

    logic       clk;
    logic       rst;
    logic [2:0] ALUOp;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] ALUControl;
    logic       WordOp;

    int n_cmp;
    int n_err;

    alu_control dut (
        .clk        (clk),
        .rst        (rst),
        .ALUOp      (ALUOp),
        .funct3     (funct3),
        .funct7     (funct7),
        .ALUControl (ALUControl),
        .WordOp     (WordOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a new input vector on the falling edge.
    task automatic drive(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7);
        @(negedge clk);
        ALUOp  = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; ALUOp = 3'b000; funct3 = 3'd6; funct7 = 7'h00;
        tick();
        n_cmp++;
        if ({ALUControl, WordOp} !== {4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL reset_hold: got %b/%b want 0000/0", ALUControl, WordOp);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({ALUControl, WordOp} !== {4'b0001, 1'b0}) begin
            n_err++;
            $display("FAIL reset_release: got %b/%b want 0001/0", ALUControl, WordOp);
        end
    endtask

    task automatic test_rtype();
        logic [3:0] exp_r [8];
        exp_r = '{4'b0101, 4'b0000, 4'b0111, 4'b0100, 4'b0110, 4'b0011, 4'b0001, 4'b0010};
        for (int i = 0; i < 8; i++) begin
            drive(3'b000, 3'(i), 7'h00);
            tick();
            n_cmp++;
            if ({ALUControl, WordOp} !== {exp_r[i], 1'b0}) begin
                n_err++;
                $display("FAIL rtype_f3_%0d: got %b/%b want %b/0", i, ALUControl, WordOp, exp_r[i]);
            end
        end
        drive(3'b000, 3'd1, 7'h20);
        tick();
        n_cmp++;
        if ({ALUControl, WordOp} !== {4'b0000, 1'b1}) begin
            n_err++;
            $display("FAIL rtype_addw: got %b/%b want 0000/1", ALUControl, WordOp);
        end
        // funct7=0x20 on a non-add funct3 must not raise WordOp
        drive(3'b000, 3'd6, 7'h20);
        tick();
        n_cmp++;
        if ({ALUControl, WordOp} !== {4'b0001, 1'b0}) begin
            n_err++;
            $display("FAIL rtype_sub_f7_20: got %b/%b want 0001/0", ALUControl, WordOp);
        end
        drive(3'b000, 3'd1, 7'h01);
        tick();
        n_cmp++;
        if ({ALUControl, WordOp} !== {4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL rtype_add_f7_01: got %b/%b want 0000/0", ALUControl, WordOp);
        end
    endtask

    task automatic test_itype();
        logic [3:0] exp_i [8];
        logic       exp_w [8];
        exp_i = '{4'b0000, 4'b0000, 4'b0111, 4'b0100, 4'b0110, 4'b0101, 4'b0010, 4'b0011};
        exp_w = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            // funct7 is non-zero to show it is ignored for I-type
            drive(3'b001, 3'(i), 7'h20);
            tick();
            n_cmp++;
            if ({ALUControl, WordOp} !== {exp_i[i], exp_w[i]}) begin
                n_err++;
                $display("FAIL itype_f3_%0d: got %b/%b want %b/%b", i, ALUControl, WordOp, exp_i[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_fixed_classes();
        logic [2:0] ops  [10];
        logic [2:0] f3s  [10];
        logic [3:0] exps [10];
        ops  = '{3'b010, 3'b010, 3'b011, 3'b011, 3'b101, 3'b101, 3'b110, 3'b111, 3'b100, 3'b111};
        f3s  = '{3'd2,   3'd0,   3'd0,   3'd2,   3'd0,   3'd1,   3'd5,   3'd0,   3'd6,   3'd1};
        exps = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b1000};
        for (int i = 0; i < 10; i++) begin
            drive(ops[i], f3s[i], 7'h20);
            tick();
            n_cmp++;
            if ({ALUControl, WordOp} !== {exps[i], 1'b0}) begin
                n_err++;
                $display("FAIL fixed_op%b_f3_%0d: got %b/%b want %b/0", ops[i], f3s[i], ALUControl, WordOp, exps[i]);
            end
        end
    endtask

    task automatic test_latency();
        drive(3'b111, 3'd0, 7'h00);
        tick();
        n_cmp++;
        if ({ALUControl, WordOp} !== {4'b1000, 1'b0}) begin
            n_err++;
            $display("FAIL latency_setup: got %b/%b want 1000/0", ALUControl, WordOp);
        end
        // Change inputs mid-cycle: output must hold the previous decode.
        #2;
        ALUOp = 3'b000; funct3 = 3'd1; funct7 = 7'h20;
        #1;
        n_cmp++;
        if ({ALUControl, WordOp} !== {4'b1000, 1'b0}) begin
            n_err++;
            $display("FAIL latency_hold: got %b/%b want 1000/0", ALUControl, WordOp);
        end
        tick();
        n_cmp++;
        if ({ALUControl, WordOp} !== {4'b0000, 1'b1}) begin
            n_err++;
            $display("FAIL latency_update: got %b/%b want 0000/1", ALUControl, WordOp);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops  [6];
        logic [2:0] f3s  [6];
        logic [6:0] f7s  [6];
        logic [3:0] exps [6];
        logic       expw [6];
        ops  = '{3'b000, 3'b111, 3'b001, 3'b101, 3'b000, 3'b001};
        f3s  = '{3'd3,   3'd0,   3'd0,   3'd0,   3'd1,   3'd5};
        f7s  = '{7'h00,  7'h00,  7'h00,  7'h00,  7'h20,  7'h00};
        exps = '{4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0101};
        expw = '{1'b0,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], f3s[i], f7s[i]);
            tick();
            n_cmp++;
            if ({ALUControl, WordOp} !== {exps[i], expw[i]}) begin
                n_err++;
                $display("FAIL b2b_%0d: got %b/%b want %b/%b", i, ALUControl, WordOp, exps[i], expw[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        drive(3'b111, 3'd0, 7'h00);
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({ALUControl, WordOp} !== {4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset: got %b/%b want 0000/0", ALUControl, WordOp);
        end
        drive(3'b001, 3'd0, 7'h00);
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({ALUControl, WordOp} !== {4'b0000, 1'b1}) begin
            n_err++;
            $display("FAIL post_reset_load: got %b/%b want 0000/1", ALUControl, WordOp);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        ALUOp  = 3'b000;
        funct3 = 3'd0;
        funct7 = 7'h00;
        test_reset();
        test_rtype();
        test_itype();
        test_fixed_classes();
        test_latency();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
